dcache_dm: RTL
==============

DCACHE_DM -- requirements
Module: dcache_dm

Interface
REQ-001 The block SHALL have parameter LINES, default 8, the number of cache lines (power of two, 2..64).
REQ-002 The block SHALL have port clk, input, 1, clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 The block SHALL have port proc_read, input, 1, load request from the memory stage.
REQ-005 The block SHALL have port proc_write, input, 1, store request from the memory stage.
REQ-006 The block SHALL have port proc_addr, input, 30, word address.
REQ-007 The block SHALL have port proc_wdata, input, 32, store data, already in memory byte order.
REQ-008 The block SHALL have port proc_rdata, output, 32, load data, in memory byte order.
REQ-009 The block SHALL have port proc_stall, output, 1, freeze of the memory stage and all upstream stages.
REQ-010 The block SHALL have port mem_read, output, 1, line fetch request.
REQ-011 The block SHALL have port mem_write, output, 1, line write-back request.
REQ-012 The block SHALL have port mem_addr, output, 28, line address.
REQ-013 The block SHALL have port mem_wdata, output, 128, victim line data.
REQ-014 The block SHALL have port mem_rdata, input, 128, fetched line data.
REQ-015 The block SHALL have port mem_ready, input, 1, one-cycle completion pulse for the current mem request.

Function
REQ-016 The block SHALL be a direct-mapped, write-back, write-allocate cache of LINES lines; each line holds 4 words, valid, dirty and tag.
REQ-017 The block SHALL decode proc_addr as: offset = [1:0]; index = next log2(LINES) bits; tag = remaining upper bits.
REQ-018 The block SHALL store word w of a line at line bits [32w+31:32w]; no byte swapping.
REQ-019 The block SHALL implement FSM states IDLE, WRITEBACK and ALLOCATE.
REQ-020 A hit SHALL be: state IDLE, a request present, and the indexed line valid with a matching tag.
REQ-021 On a read hit, the block SHALL drive proc_rdata combinationally in the same cycle with proc_stall=0.
REQ-022 On a write hit, the block SHALL write the word and set dirty at the clock edge, with proc_stall=0.
REQ-023 With no request, the block SHALL hold proc_stall=0, and proc_rdata is don't-care.
REQ-024 On a miss, the block SHALL assert proc_stall combinationally and keep it asserted until the IDLE cycle in which the access hits.
REQ-025 On a miss where the victim is valid and dirty, the FSM SHALL go IDLE->WRITEBACK; otherwise IDLE->ALLOCATE.
REQ-026 In WRITEBACK, the block SHALL drive mem_write=1, mem_addr={victim tag,index} and mem_wdata=victim line; on mem_ready, it SHALL go to ALLOCATE.
REQ-027 In ALLOCATE, the block SHALL drive mem_read=1 and mem_addr=proc_addr[29:2]; on mem_ready, it SHALL load mem_rdata, set valid=1, dirty=0 and the new tag, then go to IDLE.
REQ-028 The access SHALL complete as a hit on the first IDLE cycle after a refill; a store merges in that cycle and sets dirty.
REQ-029 mem_read and mem_write SHALL never both be 1, and both SHALL be 0 in IDLE; mem_ready SHALL be ignored in IDLE.
REQ-030 The block SHALL require proc_* inputs to be held stable while proc_stall=1.
REQ-031 If proc_read and proc_write are both 1, the access SHALL be treated as a write.
REQ-032 Miss latency SHALL be: 1 IDLE cycle + memory wait(s) + 1 IDLE hit cycle.

Reset
REQ-033 When rst_n=0 at a clock edge, the block SHALL clear all valid and dirty bits and set state to IDLE; tag and data contents are don't-care.
REQ-034 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abort: mem_read and mem_write are 0 from the next cycle, and the pending dirty data is discarded.
REQ-035 After reset, the block SHALL drive proc_stall=0 when there is no request, and mem_read=mem_write=0.

Configuration
REQ-036 With macro DCACHE_STATS_EN defined, the block SHALL add outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
REQ-037 With DCACHE_STATS_EN defined, hit_count SHALL increment once per completed access that hit on its first IDLE cycle.
REQ-038 With DCACHE_STATS_EN defined, miss_count SHALL increment once per IDLE->WRITEBACK/ALLOCATE transition; both counters wrap at 2^32.
REQ-039 Without DCACHE_STATS_EN, those ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Verification
REQ-040 Reset, then read addr 0x10 with mem_ready after 3 cycles and mem_rdata word0=0xAABBCCDD -> ALLOCATE with mem_addr=0x4, then proc_rdata=0xAABBCCDD with stall low.
REQ-041 Write 0x12345678 to the now-cached addr 0x10 -> no stall, no mem traffic; a subsequent read of 0x10 returns 0x12345678.
REQ-042 Read an addr with the same index and a different tag (LINES=8: 0x30) -> WRITEBACK with mem_addr=0x4 and mem_wdata word0=0x12345678, then ALLOCATE with mem_addr=0xC.
REQ-043 Assert rst_n=0 during ALLOCATE -> mem_read=0 next cycle, state IDLE; re-reading 0x10 misses.
REQ-044 Hold mem_ready=0 for 20 cycles in ALLOCATE -> proc_stall and mem_read stay 1 and mem_addr stays stable.
REQ-045 With DCACHE_STATS_EN defined, run the sequence of REQ-040..REQ-042 -> hit_count=2 and miss_count=2.

Source files
------------

// File: rtl/dcache_dm_if.sv
// rtl/dcache_dm_if.sv - processor and memory-side bus bundle for dcache_dm
// Purpose: groups the processor request/response and the line-memory
//          request/response signals of the direct-mapped data cache.
// Ports (signals):
//   proc_read, proc_write, proc_addr[29:0], proc_wdata[31:0]  -> cache
//   proc_rdata[31:0], proc_stall                               <- cache
//   mem_read, mem_write, mem_addr[27:0], mem_wdata[127:0]      <- cache
//   mem_rdata[127:0], mem_ready                                -> cache
// Modports: master = memory stage + line memory side, slave = the cache.
interface dcache_dm_if;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic [31:0]  proc_rdata;
    logic         proc_stall;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_dm.sv
// rtl/dcache_dm.sv - direct-mapped write-back write-allocate data cache
// Purpose: LINES lines of 4 x 32-bit words. Hits complete in the request
//          cycle; misses stall, optionally write back a dirty victim, refill
//          the line and then complete as a hit on the next IDLE cycle.
// Ports:
//   clk            clock, rising edge
//   rst_n          synchronous active-low reset (clears valid/dirty, FSM IDLE)
//   bus            dcache_dm_if.slave (processor and line-memory signals)
//   hit_count      [31:0] completed first-cycle hits   (DCACHE_STATS_EN only)
//   miss_count     [31:0] misses started                (DCACHE_STATS_EN only)
// Optional feature macro: DCACHE_STATS_EN (hit/miss counters).
module dcache_dm #(
    parameter int LINES = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_dm_if.slave  bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 28 - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_W-1:0] tag_mem  [LINES];
    logic [127:0]     data_mem [LINES];

    logic             req;
    logic             hit;
    logic [1:0]       off;
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [127:0]     line_cur;
    logic [127:0]     line_merged;
    logic             refill_done;

    // A simultaneous read and write is a write, so only "any request" and
    // proc_write matter below.
    assign req = bus.proc_read | bus.proc_write;
    assign off = bus.proc_addr[1:0];
    assign idx = bus.proc_addr[IDX_W+1:2];
    assign tag = bus.proc_addr[29:IDX_W+2];

    assign line_cur    = data_mem[idx];
    assign hit         = (state == IDLE) && req && valid[idx] && (tag_mem[idx] == tag);
    assign refill_done = (state == ALLOCATE) && bus.mem_ready;

    // Store data merged into the indexed line; word w lives at [32w+31:32w].
    always_comb begin
        line_merged = line_cur;
        line_merged[{off, 5'b0} +: 32] = bus.proc_wdata;
    end

    // Processor-side outputs are purely combinational so a hit never stalls.
    assign bus.proc_rdata = line_cur[{off, 5'b0} +: 32];
    assign bus.proc_stall = req && !hit;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and memory-side outputs
    always_comb begin
        state_nxt     = state;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = bus.proc_addr[29:2];
        bus.mem_wdata = line_cur;
        unique case (state)
            IDLE: begin
                if (req && !hit) begin
                    state_nxt = (valid[idx] && dirty[idx]) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = {tag_mem[idx], idx};
                if (bus.mem_ready) begin
                    state_nxt = ALLOCATE;
                end
            end
            ALLOCATE: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Line status bits: the only cache state that reset must clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
            dirty <= '0;
        end else if (refill_done) begin
            valid[idx] <= 1'b1;
            dirty[idx] <= 1'b0;
        end else if (hit && bus.proc_write) begin
            dirty[idx] <= 1'b1;
        end
    end

    // Tag and data arrays carry no reset; their contents are qualified by valid.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (refill_done) begin
                data_mem[idx] <= bus.mem_rdata;
                tag_mem[idx]  <= tag;
            end else if (hit && bus.proc_write) begin
                data_mem[idx] <= line_merged;
            end
        end
    end

`ifdef DCACHE_STATS_EN
    // miss_pending marks that the current access already missed, so its
    // completing hit after the refill is not counted as a hit.
    logic miss_pending;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_count    <= '0;
            miss_count   <= '0;
            miss_pending <= 1'b0;
        end else begin
            if ((state == IDLE) && req && !hit) begin
                miss_count   <= miss_count + 32'd1;
                miss_pending <= 1'b1;
            end
            if (hit) begin
                if (!miss_pending) begin
                    hit_count <= hit_count + 32'd1;
                end
                miss_pending <= 1'b0;
            end
        end
    end
`endif

endmodule
